systolic_ws_result_collector: RTL and testbench

- Downstream stage of the weight-stationary systolic controller and array.
- Captures the column-staggered result writes: each column c emits rows 0..ROW_NUM-1 on consecutive cycles, and column c starts one cycle after column c-1.
- Reassembles complete output rows in an internal ROW_NUM x COL_NUM register buffer.
- Streams whole rows, in row order, to the result consumer over a val/rdy handshake.

---
 rtl/systolic_ws_result_collector.sv | 135 +++++++++++++
 tb/tb_systolic_ws_result_collector.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ws_result_collector.sv
// Result collector for the weight-stationary systolic array: gathers column-staggered
// writes into a ROW_NUM x COL_NUM buffer and streams complete rows in order over val/rdy.

module systolic_ws_result_collector_col #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROW_NUM        = 8,
  parameter int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ROW_ADDR_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      clr_en,
  input  logic [ROW_ADDR_WIDTH-1:0] rd_row,
  output logic [ROW_NUM-1:0]        vld,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      ovf
);
  logic [ROW_NUM-1:0][DATA_WIDTH-1:0] mem;
  logic                               clr_hit;

  // A write landing on the row being drained sees the slot as already free.
  assign clr_hit = clr_en && (rd_row == wraddr);
  assign ovf     = wr_en && vld[wraddr] && !clr_hit;
  assign rd_data = mem[rd_row];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      mem <= '0;
    end else begin
      if (clr_en) vld[rd_row] <= 1'b0;
      if (wr_en && (!vld[wraddr] || clr_hit)) begin
        vld[wraddr] <= 1'b1;
        mem[wraddr] <= data;
      end
    end
  end
endmodule

module systolic_ws_result_collector #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROW_NUM        = 8,
  parameter int COL_NUM        = 8,
  parameter int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [0:COL_NUM-1]                    col_wr_en,
  input  logic [0:COL_NUM-1][ROW_ADDR_WIDTH-1:0] col_wraddr,
  input  logic [0:COL_NUM-1][DATA_WIDTH-1:0]    col_data,
  output logic                                  out_val,
  input  logic                                  out_rdy,
  output logic [ROW_ADDR_WIDTH-1:0]             out_row_idx,
  output logic [0:COL_NUM-1][DATA_WIDTH-1:0]    out_row_data,
  output logic                                  tile_done,
  output logic                                  overflow_err
);
  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [ROW_ADDR_WIDTH-1:0]        rd_ptr;
  logic [0:COL_NUM-1][ROW_NUM-1:0]  vld_col;
  logic [0:COL_NUM-1]               ovf_col;
  logic [ROW_NUM-1:0]               row_full, row_any;
  logic                             xfer, last_xfer, other_pending;

  for (genvar c = 0; c < COL_NUM; c++) begin : g_col
    systolic_ws_result_collector_col #(
      .DATA_WIDTH(DATA_WIDTH), .ROW_NUM(ROW_NUM), .ROW_ADDR_WIDTH(ROW_ADDR_WIDTH)
    ) u_col (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (col_wr_en[c]),
      .wraddr (col_wraddr[c]),
      .data   (col_data[c]),
      .clr_en (xfer),
      .rd_row (rd_ptr),
      .vld    (vld_col[c]),
      .rd_data(out_row_data[c]),
      .ovf    (ovf_col[c])
    );
  end

  always_comb begin
    row_full = '1;
    row_any  = '0;
    for (int r = 0; r < ROW_NUM; r++)
      for (int c = 0; c < COL_NUM; c++) begin
        row_full[r] = row_full[r] & vld_col[c][r];
        row_any[r]  = row_any[r] | vld_col[c][r];
      end
  end

  assign out_val     = row_full[rd_ptr];
  assign out_row_idx = rd_ptr;
  assign xfer        = out_val && out_rdy;
  assign last_xfer   = xfer && (rd_ptr == LAST_ROW);

  // Anything already landed in rows other than the one draining belongs to the next tile.
  always_comb begin
    other_pending = 1'b0;
    for (int r = 0; r < ROW_NUM; r++)
      if (ROW_ADDR_WIDTH'(r) != rd_ptr) other_pending = other_pending | row_any[r];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|col_wr_en) state_nxt = COLLECT;
      COLLECT: if (last_xfer && !(|col_wr_en) && !other_pending) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      tile_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      tile_done <= last_xfer;
      if (|ovf_col) overflow_err <= 1'b1;
      if (xfer) rd_ptr <= (rd_ptr == LAST_ROW) ? '0 : rd_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_systolic_ws_result_collector.sv
// Bench for systolic_ws_result_collector: scoreboarded row stream with per-edge snapshots.

module tb_systolic_ws_result_collector;
  localparam int DW = 16, RN = 4, CN = 4, AW = 2;

  logic clk = 1'b0;
  logic reset;
  logic [0:CN-1]          col_wr_en;
  logic [0:CN-1][AW-1:0]  col_wraddr;
  logic [0:CN-1][DW-1:0]  col_data;
  logic                   out_val, out_rdy, tile_done, overflow_err;
  logic [AW-1:0]          out_row_idx;
  logic [0:CN-1][DW-1:0]  out_row_data;

  systolic_ws_result_collector #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)) dut (
    .clk(clk), .reset(reset), .col_wr_en(col_wr_en), .col_wraddr(col_wraddr),
    .col_data(col_data), .out_val(out_val), .out_rdy(out_rdy), .out_row_idx(out_row_idx),
    .out_row_data(out_row_data), .tile_done(tile_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]         idx;
    logic [0:CN-1][DW-1:0] data;
    int                    ed;
  } row_t;

  row_t exp_q[$], obs_q[$];
  row_t xr, orow;
  int total = 0, bad = 0;

  logic                  snap_val [64];
  logic [AW-1:0]         snap_idx [64];
  logic [0:CN-1][DW-1:0] snap_data[64];
  logic                  snap_ovf [64];
  logic                  snap_td  [64];
  logic                  snap_st  [64];

  // Snapshot in the cycle before edge e, then take edge e.
  task automatic tick(input int e);
    @(negedge clk);
    snap_val[e]  = out_val;
    snap_idx[e]  = out_row_idx;
    snap_data[e] = out_row_data;
    snap_ovf[e]  = overflow_err;
    snap_td[e]   = tile_done;
    snap_st[e]   = dut.state;
    if (out_val && out_rdy) obs_q.push_back('{idx: out_row_idx, data: out_row_data, ed: e});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    col_wr_en = '0; col_wraddr = '0; col_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_in();
    out_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete(); obs_q.delete();
  endtask

  // Staggered tile starting at edge 'base': column c writes row r at edge base+c+r.
  task automatic drive_fill(input int e, input int base, input logic [DW-1:0] tag);
    for (int c = 0; c < CN; c++) begin
      int r;
      r = e - base - c;
      if (r >= 0 && r < RN) begin
        col_wr_en[c]  = 1'b1;
        col_wraddr[c] = AW'(r);
        col_data[c]   = tag | DW'(r << 4) | DW'(c);
      end
    end
  endtask

  task automatic push_tile(input logic [DW-1:0] tag, input int first_edge);
    for (int r = 0; r < RN; r++) begin
      row_t t;
      t.idx = AW'(r);
      for (int c = 0; c < CN; c++) t.data[c] = tag | DW'(r << 4) | DW'(c);
      t.ed = first_edge + r;
      exp_q.push_back(t);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    col_wr_en[0] = 1'b1; col_wraddr[0] = 0; col_data[0] = 16'h1111;
    tick(0);
    tick(1);
    col_wr_en = 4'b0111; col_data[1] = 16'h2; col_data[2] = 16'h3; col_data[3] = 16'h4;
    tick(2);
    clear_in();
    total++;
    if (out_val !== 1'b1 || overflow_err !== 1'b1) begin
      bad++; $display("FAIL reset_pre: val=%b ovf=%b want 1 1", out_val, overflow_err);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_val !== 1'b0 || tile_done !== 1'b0 || overflow_err !== 1'b0 || out_row_idx !== '0) begin
      bad++;
      $display("FAIL reset_async: val=%b td=%b ovf=%b idx=%0d want all 0",
               out_val, tile_done, overflow_err, out_row_idx);
    end
    apply_reset();
  endtask

  task automatic test_free_run();
    apply_reset();
    out_rdy = 1'b1;
    push_tile(16'h0000, 4);
    for (int e = 0; e < 10; e++) begin
      clear_in(); drive_fill(e, 0, 16'h0000); tick(e);
    end
    total++;
    if (snap_val[3] !== 1'b0) begin bad++; $display("FAIL free_early: val=%b want 0", snap_val[3]); end
    total++;
    if (snap_val[4] !== 1'b1 || snap_data[4] !== 64'h0000_0001_0002_0003) begin
      bad++; $display("FAIL free_row0: val=%b data=%h want 1 0000000100020003", snap_val[4], snap_data[4]);
    end
    while (exp_q.size() > 0) begin
      xr = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL free_stream: missing row %0d, want edge %0d", xr.idx, xr.ed);
      end else begin
        orow = obs_q.pop_front();
        if (orow !== xr) begin
          bad++; $display("FAIL free_stream: got idx=%0d data=%h edge=%0d want idx=%0d data=%h edge=%0d",
                          orow.idx, orow.data, orow.ed, xr.idx, xr.data, xr.ed);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL free_extra: %0d extra rows, want 0", obs_q.size()); end
    for (int e = 0; e < 10; e++) begin
      total++;
      if (snap_td[e] !== (e == 8)) begin bad++; $display("FAIL free_tile_done@%0d: got %b want %b", e, snap_td[e], e == 8); end
    end
    total++;
    if (snap_st[2] !== 1'b1 || snap_st[8] !== 1'b0) begin
      bad++; $display("FAIL free_fsm: st2=%b st8=%b want 1 0", snap_st[2], snap_st[8]);
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    push_tile(16'h0000, 10);
    for (int e = 0; e < 16; e++) begin
      clear_in(); drive_fill(e, 0, 16'h0000); out_rdy = (e >= 10); tick(e);
    end
    for (int e = 4; e <= 10; e++) begin
      total++;
      if (snap_val[e] !== 1'b1 || snap_idx[e] !== 2'd0 || snap_data[e] !== 64'h0000_0001_0002_0003) begin
        bad++; $display("FAIL bp_hold@%0d: val=%b idx=%0d data=%h want 1 0 0000000100020003",
                        e, snap_val[e], snap_idx[e], snap_data[e]);
      end
    end
    while (exp_q.size() > 0) begin
      xr = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL bp_stream: missing row %0d, want edge %0d", xr.idx, xr.ed);
      end else begin
        orow = obs_q.pop_front();
        if (orow !== xr) begin
          bad++; $display("FAIL bp_stream: got idx=%0d data=%h edge=%0d want idx=%0d data=%h edge=%0d",
                          orow.idx, orow.data, orow.ed, xr.idx, xr.data, xr.ed);
        end
      end
    end
    for (int e = 0; e < 16; e++) begin
      total++;
      if (snap_td[e] !== (e == 14)) begin bad++; $display("FAIL bp_tile_done@%0d: got %b want %b", e, snap_td[e], e == 14); end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    col_wr_en[0] = 1'b1; col_wraddr[0] = 0; col_data[0] = 16'hAAAA;
    tick(0);
    col_data[0] = 16'hBBBB;
    tick(1);
    col_wr_en = 4'b0111; col_data[1] = 16'h1; col_data[2] = 16'h2; col_data[3] = 16'h3;
    tick(2);
    clear_in();
    tick(3);
    tick(4);
    out_rdy = 1'b1;
    tick(5);
    tick(6);
    total++;
    if (snap_ovf[1] !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", snap_ovf[1]); end
    total++;
    if (snap_ovf[2] !== 1'b1 || snap_ovf[4] !== 1'b1 || snap_ovf[6] !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: %b%b%b want 111", snap_ovf[2], snap_ovf[4], snap_ovf[6]);
    end
    total++;
    if (snap_val[3] !== 1'b1 || snap_data[3] !== 64'hAAAA_0001_0002_0003) begin
      bad++; $display("FAIL ovf_data: val=%b data=%h want 1 AAAA000100020003", snap_val[3], snap_data[3]);
    end
  endtask

  task automatic test_reset_mid_tile();
    apply_reset();
    for (int e = 0; e < 5; e++) begin
      clear_in(); drive_fill(e, 0, 16'h0000); tick(e);
    end
    clear_in();
    total++;
    if (out_val !== 1'b1) begin bad++; $display("FAIL mid_pre: val=%b want 1", out_val); end
    reset = 1'b1;
    #1;
    total++;
    if (out_val !== 1'b0) begin bad++; $display("FAIL mid_reset: val=%b want 0", out_val); end
    apply_reset();
    out_rdy = 1'b1;
    push_tile(16'h0500, 4);
    for (int e = 0; e < 10; e++) begin
      clear_in(); drive_fill(e, 0, 16'h0500); tick(e);
    end
    total++;
    if (snap_val[3] !== 1'b0) begin bad++; $display("FAIL mid_stale: val=%b want 0", snap_val[3]); end
    while (exp_q.size() > 0) begin
      xr = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL mid_stream: missing row %0d, want edge %0d", xr.idx, xr.ed);
      end else begin
        orow = obs_q.pop_front();
        if (orow !== xr) begin
          bad++; $display("FAIL mid_stream: got idx=%0d data=%h edge=%0d want idx=%0d data=%h edge=%0d",
                          orow.idx, orow.data, orow.ed, xr.idx, xr.data, xr.ed);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_rdy = 1'b1;
    push_tile(16'h0000, 4);
    push_tile(16'h1000, 8);
    for (int e = 0; e < 14; e++) begin
      clear_in(); drive_fill(e, 0, 16'h0000); drive_fill(e, 4, 16'h1000); tick(e);
    end
    total++;
    if (snap_data[8][0] !== 16'h1000) begin bad++; $display("FAIL b2b_first: got %h want 1000", snap_data[8][0]); end
    while (exp_q.size() > 0) begin
      xr = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL b2b_stream: missing row %0d, want edge %0d", xr.idx, xr.ed);
      end else begin
        orow = obs_q.pop_front();
        if (orow !== xr) begin
          bad++; $display("FAIL b2b_stream: got idx=%0d data=%h edge=%0d want idx=%0d data=%h edge=%0d",
                          orow.idx, orow.data, orow.ed, xr.idx, xr.data, xr.ed);
        end
      end
    end
    total++;
    if (snap_ovf[13] !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", snap_ovf[13]); end
    total++;
    if (snap_st[8] !== 1'b1) begin bad++; $display("FAIL b2b_fsm: state=%b want 1", snap_st[8]); end
    total++;
    if (snap_td[8] !== 1'b1 || snap_td[12] !== 1'b1 || snap_td[10] !== 1'b0) begin
      bad++; $display("FAIL b2b_tile_done: %b%b%b want 101", snap_td[8], snap_td[10], snap_td[12]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    out_rdy = 1'b0;
    clear_in();
    test_reset();
    test_free_run();
    test_back_pressure();
    test_overflow();
    test_reset_mid_tile();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
